// File: rtl/packet_error_monitor.sv
// packet_error_monitor
// Watches per-source error strobes against a frame-valid envelope, flags each
// invalid frame exactly once (including errors that arrive shortly after the
// frame ends), keeps a drop indication for the rest of the errored frame and
// maintains saturating per-source and per-frame error statistics.
module packet_error_monitor #(
    parameter int NUM_SRC  = 4,
    parameter int CNT_W    = 16,
    parameter int LATE_WIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_valid_i,
    input  logic [NUM_SRC-1:0]       err_src_i,
    input  logic [NUM_SRC-1:0]       err_mask_i,
    input  logic                     cnt_clear_i,
    output logic                     error_pulse_o,
    output logic                     drop_o,
    output logic [NUM_SRC-1:0]       error_cause_o,
    output logic [NUM_SRC*CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0]         bad_frame_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GOOD = 2'd1;
    localparam logic [1:0] ST_BAD  = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    // Last tail-counter value before the late-error window closes.
    localparam int         TAIL_LAST_I = (LATE_WIN > 0) ? (LATE_WIN - 1) : 0;
    localparam logic [3:0] TAIL_LAST   = TAIL_LAST_I[3:0];
    localparam logic       HAS_TAIL    = (LATE_WIN > 0);

    // Saturating increment: a counter at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [3:0]         tail_q;
    logic [3:0]         tail_d;
    logic [NUM_SRC-1:0] qual_s;
    logic               err_s;
    logic               pulse_s;
    logic [NUM_SRC-1:0] cause_q;
    logic [NUM_SRC-1:0] cause_d;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic [CNT_W-1:0]   bad_q;
    logic [CNT_W-1:0]   bad_d;

    // A masked source never contributes, even in a cycle where the mask changes.
    assign qual_s = err_src_i & err_mask_i;
    assign err_s  = |qual_s;

    // Frame tracking: decides the one-per-frame pulse and the next state.
    always_comb begin
        state_d = state_q;
        tail_d  = 4'd0;
        pulse_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    if (err_s) begin
                        pulse_s = 1'b1;
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_GOOD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GOOD: begin
                if (err_s) begin
                    pulse_s = 1'b1;
                    if (frame_valid_i) begin
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (frame_valid_i) begin
                    state_d = ST_GOOD;
                end else if (HAS_TAIL) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BAD: begin
                // Already flagged: further errors in this frame are silent.
                if (frame_valid_i) begin
                    state_d = ST_BAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TAIL: begin
                if (err_s) begin
                    // Late error belongs to the frame that just ended; a frame
                    // starting in this very cycle inherits the drop.
                    pulse_s = 1'b1;
                    if (frame_valid_i) begin
                        state_d = ST_BAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (frame_valid_i) begin
                    state_d = ST_GOOD;
                end else if (tail_q == TAIL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TAIL;
                    tail_d  = tail_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Statistics and cause capture; a clear overrides any same-cycle increment.
    always_comb begin
        bad_d = bad_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (cnt_clear_i) begin
            bad_d = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_d[i] = '0;
            end
        end else if (pulse_s) begin
            bad_d = sat_inc(bad_q);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (qual_s[i]) begin
                    cnt_d[i] = sat_inc(cnt_q[i]);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end else begin
            bad_d = bad_q;
        end
        if (pulse_s) begin
            cause_d = qual_s;
        end else begin
            cause_d = cause_q;
        end
    end

    // State, tail counter, cause and counters; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tail_q  <= 4'd0;
            cause_q <= '0;
            bad_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            cause_q <= cause_d;
            bad_q   <= bad_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack the per-source counters onto the flat output bus.
    always_comb begin
        err_cnt_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            err_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign error_pulse_o   = pulse_s;
    assign drop_o          = pulse_s | (state_q == ST_BAD);
    assign error_cause_o   = cause_q;
    assign bad_frame_cnt_o = bad_q;

endmodule

// File: tb/tb_packet_error_monitor.sv
// Bench for packet_error_monitor: two instances (16-bit and 2-bit counters)
// share stimulus; a frame-level reference model predicts pulse/drop/cause and
// raw error counts, saturation being applied when comparing.
module tb_packet_error_monitor;

    localparam int LW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fv = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  src = 4'd0;
    logic [3:0]  mask = 4'hF;

    logic        pulse, drop, pulse_s, drop_s;
    logic [3:0]  cause, cause_s;
    logic [63:0] cnt;
    logic [15:0] bad;
    logic [7:0]  cnt_s;
    logic [1:0]  bad_s;

    always #5 clk = ~clk;

    packet_error_monitor #(.NUM_SRC(4), .CNT_W(16), .LATE_WIN(LW)) dut (
        .clk(clk), .rst(rst), .frame_valid_i(fv), .err_src_i(src), .err_mask_i(mask),
        .cnt_clear_i(clr), .error_pulse_o(pulse), .drop_o(drop), .error_cause_o(cause),
        .err_cnt_o(cnt), .bad_frame_cnt_o(bad));

    packet_error_monitor #(.NUM_SRC(4), .CNT_W(2), .LATE_WIN(LW)) dut_s (
        .clk(clk), .rst(rst), .frame_valid_i(fv), .err_src_i(src), .err_mask_i(mask),
        .cnt_clear_i(clr), .error_pulse_o(pulse_s), .drop_o(drop_s), .error_cause_o(cause_s),
        .err_cnt_o(cnt_s), .bad_frame_cnt_o(bad_s));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame-level view (in frame? frame already bad? how many
    // idle cycles since a good frame ended?) plus raw event counts since clear.
    bit         m_prev_fv = 1'b0, m_bad = 1'b0;
    int         m_win = 0;
    logic [3:0] m_cause = 4'd0;
    int         m_raw[4] = '{0, 0, 0, 0};
    int         m_rawbad = 0;
    bit         n_prev_fv, n_bad;
    int         n_win;
    logic [3:0] n_cause;
    int         n_raw[4];
    int         n_rawbad;
    bit         have_next = 1'b0;
    bit         exp_pulse, exp_drop;

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Drive one cycle of stimulus and compute what the DUT must show in it.
    task automatic step(input logic f, input logic [3:0] s, input logic [3:0] mk,
                        input logic cl, input logic r);
        logic [3:0] q;
        bit e;
        if (have_next) begin
            m_prev_fv = n_prev_fv; m_bad = n_bad; m_win = n_win;
            m_cause = n_cause; m_raw = n_raw; m_rawbad = n_rawbad;
        end
        @(negedge clk);
        rst = r; fv = f; src = s; mask = mk; clr = cl;
        #1;
        q = s & mk;
        e = |q;
        if (r) begin
            exp_pulse = 1'b0; exp_drop = 1'b0;
            n_prev_fv = 1'b0; n_bad = 1'b0; n_win = 0; n_cause = 4'd0;
            n_raw = '{0, 0, 0, 0}; n_rawbad = 0;
        end else begin
            n_cause = m_cause; n_raw = m_raw; n_rawbad = m_rawbad;
            if (f) begin
                if (!m_prev_fv) begin
                    exp_pulse = e; n_bad = e;
                end else begin
                    exp_pulse = e && !m_bad; n_bad = m_bad || e;
                end
                n_win = 0;
            end else begin
                n_bad = 1'b0;
                if (m_prev_fv) begin
                    exp_pulse = e && !m_bad;
                    n_win = (!m_bad && !e) ? 1 : 0;
                end else if (m_win >= 1 && m_win <= LW) begin
                    exp_pulse = e;
                    n_win = e ? 0 : m_win + 1;
                end else begin
                    exp_pulse = 1'b0; n_win = 0;
                end
            end
            n_prev_fv = f;
            exp_drop = exp_pulse || (m_prev_fv && m_bad);
            if (exp_pulse) begin
                n_cause = q;
                n_rawbad++;
                for (int i = 0; i < 4; i++) n_raw[i] += int'(q[i]);
            end
            if (cl) begin
                n_raw = '{0, 0, 0, 0}; n_rawbad = 0;
            end
        end
        have_next = 1'b1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
        step(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (pulse !== 1'b0 || drop !== 1'b0) begin n_fail++; $display("FAIL reset_outputs pulse=%b drop=%b want 0 0", pulse, drop); end
        n_tests++; if (cause !== 4'd0) begin n_fail++; $display("FAIL reset_cause got %h want 0", cause); end
        n_tests++; if (cnt !== 64'd0 || bad !== 16'd0) begin n_fail++; $display("FAIL reset_counters cnt=%h bad=%h want 0", cnt, bad); end
        n_tests++; if (cnt_s !== 8'd0 || bad_s !== 2'd0) begin n_fail++; $display("FAIL reset_counters_small cnt=%h bad=%h want 0", cnt_s, bad_s); end
    endtask

    task automatic test_clean_frame();
        int bad_cyc = 0;
        for (int c = 0; c < 64; c++) begin
            step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
            if (pulse !== 1'b0 || drop !== 1'b0) bad_cyc++;
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
            if (pulse !== 1'b0 || drop !== 1'b0) bad_cyc++;
        end
        n_tests++; if (bad_cyc != 0) begin n_fail++; $display("FAIL clean_frame cycles_with_pulse_or_drop got %0d want 0", bad_cyc); end
        n_tests++; if (cnt !== 64'd0 || bad !== 16'd0) begin n_fail++; $display("FAIL clean_counters cnt=%h bad=%h want 0", cnt, bad); end
    endtask

    task automatic test_single_pulse();
        int errs = 0;
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step(1'b1, (c == 10 || c == 20) ? 4'b0110 : 4'b0000, 4'hF, 1'b0, 1'b0);
            if (pulse !== (c == 10) || drop !== (c >= 10)) begin
                errs++;
                $display("FAIL single_pulse cycle %0d pulse=%b drop=%b want %b %b", c, pulse, drop, c == 10, c >= 10);
            end
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL single_pulse_frame bad cycles got %0d want 0", errs); end
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL single_pulse_end_drop got %b want 1", drop); end
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL single_pulse_after_drop got %b want 0", drop); end
        n_tests++; if (cause !== 4'b0110) begin n_fail++; $display("FAIL single_pulse_cause got %b want 0110", cause); end
        n_tests++; if (cnt !== {16'd0, 16'd1, 16'd1, 16'd0} || bad !== 16'd1) begin n_fail++; $display("FAIL single_pulse_counts cnt=%h bad=%0d want 0000000100010000 1", cnt, bad); end
    endtask

    task automatic test_late_crc();
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
        n_tests++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL late_crc_in_window pulse got %b want 1", pulse); end
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (bad !== 16'd1 || cause !== 4'b0001) begin n_fail++; $display("FAIL late_crc_stats bad=%0d cause=%b want 1 0001", bad, cause); end
        for (int c = 0; c < 4; c++) step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'hF, 1'b0, 1'b0);
        n_tests++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL late_crc_outside_window pulse got %b want 0", pulse); end
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (bad !== 16'd1) begin n_fail++; $display("FAIL late_crc_outside_count bad got %0d want 1", bad); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int drops = 0;
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
        n_tests++; if (pulse !== 1'b1 || drop !== 1'b1) begin n_fail++; $display("FAIL b2b_tail_error pulse=%b drop=%b want 1 1", pulse, drop); end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 4'hF, 1'b0, 1'b0);
            pulses += int'(pulse);
            drops  += int'(drop);
        end
        n_tests++; if (pulses != 0 || drops != 5) begin n_fail++; $display("FAIL b2b_second_frame pulses=%0d drops=%0d want 0 5", pulses, drops); end
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (drop !== 1'b0 || bad !== 16'd1) begin n_fail++; $display("FAIL b2b_after drop=%b bad=%0d want 0 1", drop, bad); end
    endtask

    task automatic test_saturation();
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            step(1'b1, 4'b1000, 4'hF, 1'b0, 1'b0);
            step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
            for (int c = 0; c < 4; c++) step(1'b0, 4'd0, 4'hF, 1'b0, 1'b0);
        end
        n_tests++; if (cnt_s[7:6] !== 2'd3 || bad_s !== 2'd3) begin n_fail++; $display("FAIL sat_small cnt3=%0d bad=%0d want 3 3", cnt_s[7:6], bad_s); end
        n_tests++; if (cnt[63:48] !== 16'd5 || bad !== 16'd5) begin n_fail++; $display("FAIL sat_wide cnt3=%0d bad=%0d want 5 5", cnt[63:48], bad); end
        step(1'b1, 4'b1000, 4'hF, 1'b1, 1'b0);
        n_tests++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL sat_clear_pulse got %b want 1", pulse); end
        step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (cnt_s !== 8'd0 || cnt !== 64'd0 || bad !== 16'd0 || bad_s !== 2'd0) begin n_fail++; $display("FAIL sat_clear_wins cnt=%h cnt_s=%h bad=%0d want 0", cnt, cnt_s, bad); end
        n_tests++; if (cause !== 4'b1000 || drop !== 1'b1) begin n_fail++; $display("FAIL sat_clear_keeps cause=%b drop=%b want 1000 1", cause, drop); end
    endtask

    task automatic test_mask_and_reset();
        int pulses = 0;
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 4'b0001, 4'b1110, 1'b0, 1'b0);
            pulses += int'(pulse);
        end
        step(1'b0, 4'b0001, 4'b1110, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'b1110, 1'b0, 1'b0);
        n_tests++; if (pulses != 0 || cnt !== 64'd0 || bad !== 16'd0) begin n_fail++; $display("FAIL mask_ignored pulses=%0d cnt=%h bad=%0d want 0", pulses, cnt, bad); end
        step(1'b1, 4'b0001, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 4'b1110, 1'b0, 1'b0);
        n_tests++; if (drop !== 1'b1 || pulse !== 1'b0) begin n_fail++; $display("FAIL mask_no_revoke drop=%b pulse=%b want 1 0", drop, pulse); end
        step(1'b1, 4'd0, 4'hF, 1'b0, 1'b1);
        step(1'b1, 4'd0, 4'hF, 1'b0, 1'b0);
        n_tests++; if (drop !== 1'b0 || pulse !== 1'b0) begin n_fail++; $display("FAIL reset_mid_bad drop=%b pulse=%b want 0 0", drop, pulse); end
        n_tests++; if (cause !== 4'd0 || bad !== 16'd0) begin n_fail++; $display("FAIL reset_mid_bad_regs cause=%b bad=%0d want 0 0", cause, bad); end
    endtask

    task automatic test_random();
        int run = 0;
        logic fcur = 1'b0;
        logic [3:0] mk = 4'hF;
        logic [3:0] s;
        logic cl, r;
        int errs = 0;
        step(1'b0, 4'd0, 4'hF, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                fcur = !fcur;
                run = fcur ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 5));
            end
            run--;
            if ($urandom_range(0, 99) < 3) mk = 4'($urandom_range(0, 15));
            s  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cl = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(fcur, s, mk, cl, r);
            if (!r) begin
                n_tests++;
                if (pulse !== exp_pulse || drop !== exp_drop || pulse_s !== exp_pulse || drop_s !== exp_drop) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rand_pulse_drop cycle %0d pulse=%b drop=%b want %b %b", c, pulse, drop, exp_pulse, exp_drop);
                end
            end
            n_tests++;
            if (cause !== m_cause || cause_s !== m_cause || bad !== 16'(m_rawbad) || bad_s !== 2'(sat3(m_rawbad))) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_cause_bad cycle %0d cause=%b bad=%0d bad_s=%0d want %b %0d %0d", c, cause, bad, bad_s, m_cause, m_rawbad, sat3(m_rawbad));
            end
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cnt[16*i +: 16] !== 16'(m_raw[i]) || cnt_s[2*i +: 2] !== 2'(sat3(m_raw[i]))) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rand_cnt%0d cycle %0d got %0d/%0d want %0d/%0d", i, c, cnt[16*i +: 16], cnt_s[2*i +: 2], m_raw[i], sat3(m_raw[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_single_pulse();
        test_late_crc();
        test_back_to_back();
        test_saturation();
        test_mask_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
